// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side initiator for a single-port RAM with combinational read data.
//   A start command latches a first address and a word count.  The block then
//   walks ram_addr upward (wrapping at the top of the RAM) and streams each
//   word out on a valid/ready interface.  It moves one word per cycle when the
//   consumer is ready, and holds the word while the consumer stalls.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     start                 begin a burst (only honoured while idle)
//     start_addr, burst_len first word address, number of words (0 = no-op)
//     busy                  burst in progress
//     done                  one-cycle pulse when the burst has finished
//     ram_wen, ram_din      write side, tied off (this block only reads)
//     ram_addr, ram_dout    registered read address, combinational read data
//     m_valid/m_ready       output stream handshake
//     m_data, m_last        stream word and end-of-burst marker
//     sum                   (RD_SUM_EN only) modular sum of the words read
//
//   Build option
//     RD_SUM_EN  adds the sum output and its accumulator.

module ram_burst_reader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int LWIDTH = AWIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [LWIDTH-1:0] burst_len,
    output logic              busy,
    output logic              done,
    output logic              ram_wen,
    output logic [DWIDTH-1:0] ram_din,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
`ifdef RD_SUM_EN
    ,
    output logic [DWIDTH-1:0] sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [AWIDTH-1:0] r_ram_addr;
    logic [LWIDTH-1:0] r_rem;
    logic [DWIDTH-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;
    logic              w_accept;
    logic              w_load;
    logic              w_hs;
    logic              w_last_hs;
`ifdef RD_SUM_EN
    logic [DWIDTH-1:0] r_sum;
`endif

    assign w_accept  = (r_state == S_IDLE) && start;
    // A new word is fetched whenever words remain and the output slot is
    // either empty or being emptied this cycle (keeps 1 word/cycle).
    assign w_load    = (r_state == S_READ) && (r_rem != '0) && (!r_m_valid || m_ready);
    assign w_hs      = r_m_valid && m_ready;
    assign w_last_hs = (r_state == S_READ) && w_hs && r_m_last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (burst_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_last_hs) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_READ:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Address walker, remaining count and output stream register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_rem      <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ram_addr <= start_addr;
                r_rem      <= burst_len;
            end
            if (w_load) begin
                r_m_data   <= ram_dout;
                r_m_valid  <= 1'b1;
                r_m_last   <= (r_rem == LWIDTH'(1));
                r_ram_addr <= r_ram_addr + AWIDTH'(1);
                r_rem      <= r_rem - LWIDTH'(1);
            end else if (w_hs) begin
                // Slot drained with nothing to refill it; the last word
                // being taken also clears the end marker.
                r_m_valid <= 1'b0;
                if (r_m_last) begin
                    r_m_last <= 1'b0;
                end
            end
        end
    end

`ifdef RD_SUM_EN
    // Running sum of every word fetched, wrapping at the data width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_load) begin
            r_sum <= r_sum + ram_dout;
        end
    end

    assign sum = r_sum;
`endif

    assign ram_wen  = 1'b0;
    assign ram_din  = '0;
    assign ram_addr = r_ram_addr;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int LW = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          ram_wen;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RD_SUM_EN
    logic [DW-1:0] sum;
`endif

    // Behavioural RAM: combinational read of the addressed word
    logic [DW-1:0] mem [DEPTH];
    assign ram_dout = mem[ram_addr];

    always #5 clk = ~clk;

    ram_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .ram_wen    (ram_wen),
        .ram_din    (ram_din),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef RD_SUM_EN
        ,
        .sum        (sum)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Runs one burst from an idle DUT.  The expected word list is built from
    // the RAM contents up front: words mem[(addr+k) mod DEPTH], k=0..len-1.
    // mode 0: consumer always ready (exact latency checked)
    // mode 1: random ready
    // mode 2: ready pattern 0,1,0,1,1 then held high
    // start_at_c >= 0 pulses a spurious start during the burst.
    task automatic run_burst(input int addr, input int len, input int mode, input int start_at_c);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_sum;
        logic [DW-1:0] w;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        logic          prev_valid, prev_ready, prev_last;
        logic          rdy, exp_done, exp_busy;
        int            idx, c, last_c;
        int            pat[5] = '{0, 1, 0, 1, 1};

        exp_sum = '0;
        for (int k = 0; k < len; k++) begin
            w = mem[(addr + k) % DEPTH];
            exp_q.push_back(w);
            exp_sum = exp_sum + w;
        end

        start      = 1'b1;
        start_addr = addr[AW-1:0];
        burst_len  = len[LW-1:0];
        m_ready    = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; c = 1; last_c = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0;
        prev_data = '0; prev_addr = '0;

        while (1) begin
            exp_done = (len == 0) ? (c == 1) : (last_c >= 0 && c == last_c + 1);
            exp_busy = (len != 0) && (last_c < 0);
            check_val("done", 32'(done), 32'(exp_done));
            check_val("busy", 32'(busy), 32'(exp_busy));
            check_val("ram_wen", 32'(ram_wen), 32'(0));
            if (prev_valid && !prev_ready) begin
                check_val("stall_valid", 32'(m_valid), 32'(1));
                check_val("stall_data", 32'(m_data), 32'(prev_data));
                check_val("stall_last", 32'(m_last), 32'(prev_last));
                check_val("stall_addr", 32'(ram_addr), 32'(prev_addr));
            end
            if (idx >= len) check_val("no_extra_valid", 32'(m_valid), 32'(0));
            if (exp_done) begin
                check_val("word_count", 32'(idx), 32'(len));
`ifdef RD_SUM_EN
                check_val("sum", 32'(sum), 32'(exp_sum));
`endif
                break;
            end
            if (c > 4 * len + 40) begin
                check_val("timeout", 32'(0), 32'(1));
                break;
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (c <= 5) ? (pat[c-1] != 0) : 1'b1;
            endcase

            if (m_valid && rdy && idx < len) begin
                check_val("data", 32'(m_data), 32'(exp_q[idx]));
                check_val("last", 32'(m_last), 32'(idx == len - 1));
                if (mode == 0) check_val("latency", 32'(c), 32'(idx + 2));
                if (idx == len - 1) last_c = c;
                idx++;
            end

            prev_valid = m_valid; prev_ready = rdy; prev_last = m_last;
            prev_data  = m_data;  prev_addr  = ram_addr;

            m_ready = rdy;
            if (c == start_at_c) begin
                start      = 1'b1;
                start_addr = 4'd9;
                burst_len  = 5'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_valid", 32'(m_valid), 32'(0));
        check_val("rst_last", 32'(m_last), 32'(0));
        check_val("rst_addr", 32'(ram_addr), 32'(0));
        check_val("rst_data", 32'(m_data), 32'(0));
        check_val("rst_din", 32'(ram_din), 32'(0));
`ifdef RD_SUM_EN
        check_val("rst_sum", 32'(sum), 32'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(2, 4, 0, -1);
        run_burst(14, 4, 0, -1);
        run_burst(0, 3, 2, -1);
        run_burst(7, 0, 0, -1);
        run_burst(0, 6, 1, 3);
        run_burst(5, 16, 0, -1);

        // Reset in the middle of a burst abandons it
        start = 1'b1; start_addr = 4'd3; burst_len = 5'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("midrst_valid", 32'(m_valid), 32'(0));
        check_val("midrst_busy", 32'(busy), 32'(0));
        check_val("midrst_addr", 32'(ram_addr), 32'(0));
        check_val("midrst_last", 32'(m_last), 32'(0));
        rst_n = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        run_burst(1, 5, 1, -1);

        // Random contents, addresses, lengths (including > depth) and stalls
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 14; t++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
